// File: rtl/display_pkg.sv
// Shared definitions for the display timing path.
//   - 1024x768 default timing constants
//   - raster phase enumeration (ACTIVE, FRONT, SYNC, BACK)
//   - coordinate widths X_W / Y_W
//   - colour-bar table used by the optional test pattern
package display_pkg;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int H_ACTIVE_D = 1024;
  localparam int H_FP_D     = 24;
  localparam int H_SYNC_D   = 136;
  localparam int H_BP_D     = 160;
  localparam int V_ACTIVE_D = 768;
  localparam int V_FP_D     = 3;
  localparam int V_SYNC_D   = 6;
  localparam int V_BP_D     = 29;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_e;

  // Bar colours as {r, g, b}, left to right across the active line.
  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF; // white
      3'd1:    return 24'hFFFF00; // yellow
      3'd2:    return 24'h00FFFF; // cyan
      3'd3:    return 24'h00FF00; // green
      3'd4:    return 24'hFF00FF; // magenta
      3'd5:    return 24'hFF0000; // red
      3'd6:    return 24'h0000FF; // blue
      default: return 24'h000000; // black
    endcase
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous clear.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high clear of every stage
//   d_i    - WIDTH-bit input
//   q_o    - input delayed by DEPTH cycles (combinational pass-through when DEPTH=0)
module sync_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/display_timing_gen.sv
// Raster timing source and pixel sink for one display.
// Presents registered x/y/valid/vsync/frame_start to the renderers, takes their
// colour back PIPE_LAT cycles later and drives the PHY with colour, de_out and
// sync pins realigned to it (PIPE_LAT+1 cycles after x/y).
// Ports:
//   clk, reset                     - pixel clock, async active-high reset
//   x, y, valid, vsync, frame_start - raster outputs to the renderers
//   r_in, g_in, b_in               - renderer colour, PIPE_LAT cycles after x/y
//   tp_sel                         - colour-bar select (DISPLAY_TEST_PATTERN_EN only)
//   r_out, g_out, b_out, de_out    - registered pixel data to the PHY
//   hsync_pin, vsync_pin           - sync pins, polarity from SYNC_POL
// Optional feature macro: DISPLAY_TEST_PATTERN_EN (adds tp_sel and colour bars).
module display_timing_gen
  import display_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ACTIVE = V_ACTIVE_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int SYNC_POL = 0,
  parameter int PIPE_LAT = 2
) (
  input  logic           clk,
  input  logic           reset,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           valid,
  output logic           vsync,
  output logic           frame_start,
  input  logic [7:0]     r_in,
  input  logic [7:0]     g_in,
  input  logic [7:0]     b_in,
`ifdef DISPLAY_TEST_PATTERN_EN
  input  logic           tp_sel,
`endif
  output logic [7:0]     r_out,
  output logic [7:0]     g_out,
  output logic [7:0]     b_out,
  output logic           de_out,
  output logic           hsync_pin,
  output logic           vsync_pin
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > (1 << X_W) || V_TOTAL > (1 << Y_W) ||
      H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      PIPE_LAT < 0 || PIPE_LAT > 7) begin : g_param_err
    $error("display_timing_gen: timing parameters out of range");
  end

  // Last counter value of each phase; the phase register changes on the edge
  // where the counter leaves that value, so phase and counter stay in step.
  localparam logic [X_W-1:0] H_LAST  = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_A_END = X_W'(H_ACTIVE - 1);
  localparam logic [X_W-1:0] H_F_END = X_W'(H_ACTIVE + H_FP - 1);
  localparam logic [X_W-1:0] H_S_END = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] V_LAST  = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_A_END = Y_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] V_F_END = Y_W'(V_ACTIVE + V_FP - 1);
  localparam logic [Y_W-1:0] V_S_END = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  // Deasserted pin level; XOR with it turns active-high sync into pin polarity.
  localparam logic SYNC_IDLE = (SYNC_POL == 0);

  logic [X_W-1:0] h_cnt_q, h_cnt_d;
  logic [Y_W-1:0] v_cnt_q, v_cnt_d;
  phase_e         h_ph_q, h_ph_d, v_ph_q, v_ph_d;
  logic           h_wrap, v_wrap;

  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;
  logic           valid_d, hsync_d, vsync_d, fs_d, hsync_q;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
  end

  always_comb begin
    h_ph_d = h_ph_q;
    case (h_ph_q)
      ACTIVE:  if (h_cnt_q == H_A_END) h_ph_d = FRONT;
      FRONT:   if (h_cnt_q == H_F_END) h_ph_d = SYNC;
      SYNC:    if (h_cnt_q == H_S_END) h_ph_d = BACK;
      BACK:    if (h_wrap)             h_ph_d = ACTIVE;
      default:                         h_ph_d = ACTIVE;
    endcase
  end

  always_comb begin
    v_ph_d = v_ph_q;
    if (h_wrap) begin
      case (v_ph_q)
        ACTIVE:  if (v_cnt_q == V_A_END) v_ph_d = FRONT;
        FRONT:   if (v_cnt_q == V_F_END) v_ph_d = SYNC;
        SYNC:    if (v_cnt_q == V_S_END) v_ph_d = BACK;
        BACK:    if (v_wrap)             v_ph_d = ACTIVE;
        default:                         v_ph_d = ACTIVE;
      endcase
    end
  end

  always_comb begin
    valid_d = (h_ph_q == ACTIVE) && (v_ph_q == ACTIVE);
    x_d     = valid_d ? h_cnt_q : '0;
    y_d     = valid_d ? v_cnt_q : '0;
    hsync_d = (h_ph_q == SYNC);
    vsync_d = (v_ph_q == SYNC);
    fs_d    = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      h_ph_q      <= ACTIVE;
      v_ph_q      <= ACTIVE;
      x           <= '0;
      y           <= '0;
      valid       <= 1'b0;
      hsync_q     <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      h_ph_q      <= h_ph_d;
      v_ph_q      <= v_ph_d;
      x           <= x_d;
      y           <= y_d;
      valid       <= valid_d;
      hsync_q     <= hsync_d;
      vsync       <= vsync_d;
      frame_start <= fs_d;
    end
  end

  // Return path: controls delayed to match the renderer latency.
  logic [2:0] ctl_dly;
  logic       vld_dly, hs_dly, vs_dly;

  sync_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(3)) u_ctl_dly (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   ({valid, hsync_q, vsync}),
    .q_o   (ctl_dly)
  );
  assign {vld_dly, hs_dly, vs_dly} = ctl_dly;

  logic [23:0] rgb_d;

`ifdef DISPLAY_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  logic [X_W-1:0] x_dly, bar_num;
  logic [2:0]     bar_idx;
  logic           tp_q;

  sync_delay_line #(.DEPTH(PIPE_LAT), .WIDTH(X_W)) u_x_dly (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (x),
    .q_o   (x_dly)
  );

  assign bar_num = x_dly / X_W'(BAR_W);
  assign bar_idx = (bar_num > X_W'(7)) ? 3'd7 : bar_num[2:0];

  // Latched on the edge that presents (0,0); the previous frame's tail is
  // blanking, so the whole visible frame sees one selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tp_q <= 1'b0;
    else if (fs_d) tp_q <= tp_sel;
  end
`endif

  always_comb begin
    rgb_d = {r_in, g_in, b_in};
`ifdef DISPLAY_TEST_PATTERN_EN
    if (tp_q) rgb_d = bar_colour(bar_idx);
`endif
    if (!vld_dly) rgb_d = '0;
  end

  // Output stage to the PHY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_out    <= 1'b0;
      r_out     <= '0;
      g_out     <= '0;
      b_out     <= '0;
      hsync_pin <= SYNC_IDLE;
      vsync_pin <= SYNC_IDLE;
    end else begin
      de_out    <= vld_dly;
      {r_out, g_out, b_out} <= rgb_d;
      hsync_pin <= hs_dly ^ SYNC_IDLE;
      vsync_pin <= vs_dly ^ SYNC_IDLE;
    end
  end

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench for display_timing_gen on a reduced raster (24x10 total).
module tb_display_timing_gen;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3, HT = HA + HFP + HS + HBP;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1, VT = VA + VFP + VS + VBP;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid, vsync, frame_start;
  logic [7:0]  r_in = 8'hFF, g_in = 8'hFF, b_in = 8'hFF;
  logic [7:0]  r_out, g_out, b_out;
  logic        de_out, hsync_pin, vsync_pin;

  display_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(0), .PIPE_LAT(LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .x(x), .y(y), .valid(valid), .vsync(vsync), .frame_start(frame_start),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .de_out(de_out), .hsync_pin(hsync_pin), .vsync_pin(vsync_pin)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x; logic [9:0] y; logic vld; logic hs; logic vs; logic fs;
  } pix_t;
  typedef struct packed {
    logic de; logic [7:0] r; logic [7:0] g; logic [7:0] b; logic hs; logic vs;
  } pin_t;

  pin_t sb_q[$];
  pix_t in_q[$];
  int   n_tests = 0, n_fail = 0;
  int   mh, mv, cyc, last_fs, vs_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic pix_t model(input int h, input int v);
    pix_t p;
    p.vld = (h < HA) && (v < VA);
    p.x   = p.vld ? 11'(h) : 11'd0;
    p.y   = p.vld ? 10'(v) : 10'd0;
    p.hs  = (h >= HA + HFP) && (h < HA + HFP + HS);
    p.vs  = (v >= VA + VFP) && (v < VA + VFP + VS);
    p.fs  = (h == 0) && (v == 0);
    return p;
  endfunction

  // Pins the PHY should see for a pixel, given the colour the bench feeds back.
  function automatic pin_t to_pin(input pix_t p);
    pin_t e;
    e.de = p.vld;
    e.r  = p.vld ? p.x[7:0] : 8'h00;
    e.g  = p.vld ? p.y[7:0] : 8'h00;
    e.b  = p.vld ? 8'hA5 : 8'h00;
    e.hs = ~p.hs;
    e.vs = ~p.vs;
    return e;
  endfunction

  task automatic chk_idle(input string pfx);
    chk({pfx, "_xy"}, 32'({x, y}), 32'd0);
    chk({pfx, "_ctl"}, 32'({valid, vsync, frame_start, de_out}), 32'd0);
    chk({pfx, "_rgb"}, 32'({r_out, g_out, b_out}), 32'd0);
    chk({pfx, "_pins"}, 32'({hsync_pin, vsync_pin}), 32'b11);
  endtask

  task automatic restart_model();
    pin_t z;
    pix_t zp;
    z = '{de: 1'b0, r: 8'h00, g: 8'h00, b: 8'h00, hs: 1'b1, vs: 1'b1};
    zp = '0;
    mh = 0; mv = 0; cyc = 0; last_fs = -1; vs_cnt = 0;
    sb_q.delete();
    in_q.delete();
    for (int i = 0; i < LAT + 1; i++) sb_q.push_back(z);
    for (int i = 0; i < LAT; i++) in_q.push_back(zp);
    r_in = 8'hFF; g_in = 8'hFF; b_in = 8'hFF;
  endtask

  task automatic step(output logic hit);
    pix_t p, q;
    pin_t e;
    @(posedge clk);
    #1;
    p = model(mh, mv);
    chk("x", 32'(x), 32'(p.x));
    chk("y", 32'(y), 32'(p.y));
    chk("valid", 32'(valid), 32'(p.vld));
    chk("vsync", 32'(vsync), 32'(p.vs));
    chk("frame_start", 32'(frame_start), 32'(p.fs));
    e = sb_q.pop_front();
    chk("de_out", 32'(de_out), 32'(e.de));
    chk("rgb_out", 32'({r_out, g_out, b_out}), 32'({e.r, e.g, e.b}));
    chk("sync_pins", 32'({hsync_pin, vsync_pin}), 32'({e.hs, e.vs}));
    sb_q.push_back(to_pin(p));
    // Feed back the colour for the pixel presented LAT cycles ago; blanking gets FF.
    in_q.push_back(p);
    q = in_q.pop_front();
    r_in = q.vld ? q.x[7:0] : 8'hFF;
    g_in = q.vld ? q.y[7:0] : 8'hFF;
    b_in = q.vld ? 8'hA5 : 8'hFF;
    if (frame_start) begin
      if (last_fs >= 0) begin
        chk("fs_period", 32'(cyc - last_fs), 32'(HT * VT));
        chk("vsync_len", 32'(vs_cnt), 32'(VS * HT));
      end
      last_fs = cyc;
      vs_cnt = 0;
    end
    if (vsync) vs_cnt++;
    hit = p.vld && (p.x == 11'd5) && (p.y == 10'd3);
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv++;
      if (mv == VT) mv = 0;
    end
    cyc++;
  endtask

  initial begin
    logic hit;
    logic found;
    cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    #2;
    reset = 1'b0;
    restart_model();
    for (int i = 0; i < 2 * HT * VT + 10; i++) step(hit);

    // Advance to pixel (5,3) and hit reset in the middle of the cycle.
    found = 1'b0;
    for (int i = 0; i < HT * VT && !found; i++) begin
      step(hit);
      found = hit;
    end
    chk("find_5_3", 32'(found), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle("midreset");
    repeat (2) @(posedge clk);
    #1;
    chk_idle("midreset_hold");
    #2;
    reset = 1'b0;
    restart_model();
    for (int i = 0; i < 2 * HT * VT + 5; i++) step(hit);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
